// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, reset PC, NOP.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package if_stage_pkg;

  // Fetch FSM encodings
  localparam logic [1:0] S_REQ    = 2'd0;  // request on the bus
  localparam logic [1:0] S_WAIT   = 2'd1;  // request accepted, awaiting data
  localparam logic [1:0] S_HOLD   = 2'd2;  // fetched word parked in skid buffer
  localparam logic [1:0] S_CANCEL = 2'd3;  // drain a response that a redirect made stale

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // 32-bit modulo PC increment (0xFFFF_FFFC wraps to 0)
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with enable and flush; bubbles zero the whole entry.
// Latency: 1 cycle from ld_* to the D-side outputs.
// Backpressure: en=0 holds the contents; flush or ld_vld=0 under en loads a bubble.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        ld_vld,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_pc,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  // Next-state: hold, bubble, or load a delivered instruction
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (en) begin
      if (flush || !ld_vld) begin
        instr_d   = NOP_INSTR;
        pc_d      = 32'h0;
        pcplus4_d = 32'h0;
        valid_d   = 1'b0;
      end else begin
        instr_d   = ld_instr;
        pc_d      = ld_pc;
        pcplus4_d = pc_plus4(ld_pc);
        valid_d   = 1'b1;
      end
    end
  end

  // Register update with async reset to an empty (bubble) entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instrD   = instr_q;
  assign pcD      = pc_q;
  assign pcplus4D = pcplus4_q;
  assign validD   = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding addr_ok/data_ok fetch FSM, skid buffer, IF/ID register.
// Latency: zero-wait memory gives one instruction every 2 cycles; IF/ID loads 1 cycle after data_ok.
// Backpressure: stallD freezes IF/ID; a word landing during stallD parks in a one-entry skid buffer.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the instruction after a branch/jump as a delay slot.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        stallF
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        redirect;
  logic [31:0] target;
  logic        fetch_done;
  logic        ld_vld;
  logic [31:0] ld_instr;
  logic [31:0] ld_pc;
  logic        flush;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  // Redirect qualification; jump wins over branch
  always_comb begin
    redirect   = validD && !stallD && (jumpD || pcsrcD);
    target     = jumpD ? pcjumpD : pcbranchD;
    fetch_done = (state_q == S_WAIT) && inst_data_ok;
  end

  // Fetch FSM, PC and skid buffer next-state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_vld_d   = pend_vld_q;
    pend_tgt_d   = pend_tgt_q;
`endif

    case (state_q)
      S_REQ: begin
        if (inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
`ifdef BRANCH_DELAY_SLOT_EN
          // A pending target takes effect once the delay-slot fetch lands
          pc_d       = pend_vld_q ? pend_tgt_q : pc_plus4(pc_q);
          pend_vld_d = 1'b0;
`else
          pc_d = pc_plus4(pc_q);
`endif
          if (stallD) begin
            skid_instr_d = inst_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stallD) state_d = S_REQ;
      end
      S_CANCEL: begin
        if (inst_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
      // Delay slot already fetched (parked or landing now): jump straight to target
      if ((state_q == S_HOLD) || fetch_done) begin
        pc_d       = target;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = 1'b1;
        pend_tgt_d = target;
      end
`else
      pc_d = target;
      case (state_q)
        // An accepted request to the old PC leaves a stale response to drain
        S_REQ:   state_d = inst_addr_ok ? S_CANCEL : S_REQ;
        S_WAIT:  state_d = inst_data_ok ? S_REQ : S_CANCEL;
        S_HOLD:  state_d = S_REQ;
        default: state_d = state_q;
      endcase
`endif
    end
  end

  // Fetch-side state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // Pending redirect target, consumed by the delay-slot fetch completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`endif

  // Memory-side outputs, hazard stall, and IF/ID load selection
  always_comb begin
    inst_req  = (state_q == S_REQ);
    inst_addr = pc_q;
    stallF    = (state_q == S_REQ) || ((state_q == S_WAIT) && !inst_data_ok);
    ld_vld    = fetch_done || (state_q == S_HOLD);
    ld_instr  = (state_q == S_HOLD) ? skid_instr_q : inst_rdata;
    ld_pc     = (state_q == S_HOLD) ? skid_pc_q : pc_q;
`ifdef BRANCH_DELAY_SLOT_EN
    flush     = 1'b0;
`else
    flush     = redirect;
`endif
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (!stallD),
    .flush    (flush),
    .ld_vld   (ld_vld),
    .ld_instr (ld_instr),
    .ld_pc    (ld_pc),
    .instrD   (instrD),
    .pcD      (pcD),
    .pcplus4D (pcplus4D),
    .validD   (validD)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall/skid, redirect/cancel, jump priority, PC wrap, reset.
// Latency: fixed cycle-by-cycle steps with hand-computed expectations.
// Backpressure: stallD driven directly by the bench.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallD;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        jumpD;
  logic [31:0] pcjumpD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        stallF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .stallD       (stallD),
    .pcsrcD       (pcsrcD),
    .pcbranchD    (pcbranchD),
    .jumpD        (jumpD),
    .pcjumpD      (pcjumpD),
    .instrD       (instrD),
    .pcD          (pcD),
    .pcplus4D     (pcplus4D),
    .validD       (validD),
    .stallF       (stallF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive memory/stall inputs for the coming cycle and let combinational outputs settle
  task automatic drive(input logic a_ok, input logic d_ok, input logic [31:0] rd, input logic st);
    inst_addr_ok = a_ok;
    inst_data_ok = d_ok;
    inst_rdata   = rd;
    stallD       = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pcsrcD = 1'b0; pcbranchD = 32'h0; jumpD = 1'b0; pcjumpD = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_validD", {31'h0, validD}, 32'h0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);
    chk("rst_inst_req", {31'h0, inst_req}, 32'h1);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_stallF", {31'h0, stallF}, 32'h1);
    tick();
    rst = 1'b0;

    // Zero-wait fetch of 0x0 and 0x4
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("f0_addr", inst_addr, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h2008_0001, 1'b0);
    chk("f0_req_low", {31'h0, inst_req}, 32'h0);
    chk("f0_stallF_dataok", {31'h0, stallF}, 32'h0);
    tick();
    chk("f0_instrD", instrD, 32'h2008_0001);
    chk("f0_pcD", pcD, 32'h0);
    chk("f0_pcplus4D", pcplus4D, 32'h4);
    chk("f0_validD", {31'h0, validD}, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("f1_addr", inst_addr, 32'h4);
    chk("f1_stallF", {31'h0, stallF}, 32'h1);
    tick();
    chk("f1_bubble", {31'h0, validD}, 32'h0);
    drive(1'b0, 1'b1, 32'h2009_0002, 1'b0);
    tick();
    chk("f1_instrD", instrD, 32'h2009_0002);
    chk("f1_pcD", pcD, 32'h4);
    chk("f1_validD", {31'h0, validD}, 32'h1);

    // Stall for 3 cycles while 0x8 returns
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("s_addr", inst_addr, 32'h8);
    tick();
    chk("s_frozen0", instrD, 32'h2009_0002);
    drive(1'b0, 1'b1, 32'h8C0A_0000, 1'b1);
    tick();
    chk("s_frozen1", instrD, 32'h2009_0002);
    chk("s_frozen1_pcD", pcD, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("s_hold_req", {31'h0, inst_req}, 32'h0);
    chk("s_hold_stallF", {31'h0, stallF}, 32'h0);
    tick();
    chk("s_frozen2", instrD, 32'h2009_0002);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("s_rel_instrD", instrD, 32'h8C0A_0000);
    chk("s_rel_pcD", pcD, 32'h8);
    chk("s_rel_validD", {31'h0, validD}, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s_next_addr", inst_addr, 32'hC);
    chk("s_next_req", {31'h0, inst_req}, 32'h1);
    tick();
    drive(1'b0, 1'b1, 32'h2402_0005, 1'b0);
    tick();
    chk("c_pcD", pcD, 32'hC);

    // Branch to 0x40 while the fetch of 0x10 is accepted
    pcsrcD = 1'b1; pcbranchD = 32'h40;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("br_addr", inst_addr, 32'h10);
    tick();
    pcsrcD = 1'b0; pcbranchD = 32'h0;
    chk("br_bubble_valid", {31'h0, validD}, 32'h0);
    chk("br_bubble_instr", instrD, 32'h0);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("br_cancel_req", {31'h0, inst_req}, 32'h0);
    tick();
    chk("br_discard_valid", {31'h0, validD}, 32'h0);
    chk("br_discard_instr", instrD, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("br_target_addr", inst_addr, 32'h40);
    chk("br_target_req", {31'h0, inst_req}, 32'h1);
    tick();
    drive(1'b0, 1'b1, 32'h1000_FFFF, 1'b0);
    tick();
    chk("br_tgt_pcD", pcD, 32'h40);

    // Jump and branch together: jump wins
    jumpD = 1'b1; pcjumpD = 32'h100; pcsrcD = 1'b1; pcbranchD = 32'h40;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    jumpD = 1'b0; pcjumpD = 32'h0; pcsrcD = 1'b0; pcbranchD = 32'h0;
    chk("jp_bubble", {31'h0, validD}, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("jp_addr", inst_addr, 32'h100);
    tick();
    drive(1'b0, 1'b1, 32'h0800_0000, 1'b0);
    tick();
    chk("jp_pcD", pcD, 32'h100);

    // Jump to 0xFFFF_FFFC and check sequential wrap
    jumpD = 1'b1; pcjumpD = 32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    jumpD = 1'b0; pcjumpD = 32'h0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wr_addr", inst_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 32'h3C01_0001, 1'b0);
    tick();
    chk("wr_pcD", pcD, 32'hFFFF_FFFC);
    chk("wr_pcplus4D", pcplus4D, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wr_next_addr", inst_addr, 32'h0);

    // Jump to 0x200, then reset while that fetch is outstanding
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h1111_2222, 1'b0);
    tick();
    jumpD = 1'b1; pcjumpD = 32'h200;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    jumpD = 1'b0; pcjumpD = 32'h0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mr_addr_pre", inst_addr, 32'h200);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mr_req", {31'h0, inst_req}, 32'h1);
    chk("mr_addr", inst_addr, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0);
    tick();
    chk("mr_late_valid", {31'h0, validD}, 32'h0);
    chk("mr_late_req", {31'h0, inst_req}, 32'h1);
    chk("mr_late_addr", inst_addr, 32'h0);

`ifdef BRANCH_DELAY_SLOT_EN
    // Fetch 0x0..0x20, branch at 0x20 to 0x80; 0x24 is the delay slot
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'h0000_0000, 1'b0);
      tick();
    end
    chk("ds_br_pcD", pcD, 32'h20);
    pcsrcD = 1'b1; pcbranchD = 32'h80;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("ds_slot_addr", inst_addr, 32'h24);
    tick();
    pcsrcD = 1'b0; pcbranchD = 32'h0;
    drive(1'b0, 1'b1, 32'h0000_00DA, 1'b0);
    tick();
    chk("ds_slot_valid", {31'h0, validD}, 32'h1);
    chk("ds_slot_pcD", pcD, 32'h24);
    chk("ds_slot_instr", instrD, 32'h0000_00DA);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("ds_target_addr", inst_addr, 32'h80);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
